// File: rtl/dmem_pkg.sv
// Shared constants, FSM state encoding and the clog2 helper for the data-memory responder.
package dmem_pkg;

   localparam int WORD_W     = 32;
   localparam int BYTE_LANES = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   function automatic int clog2(input int value);
      int r;
      r = 32'sd0;
      for (int v = value - 32'sd1; v > 32'sd0; v = v >>> 1) begin
         r = r + 32'sd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH_WORDS x 32-bit storage: synchronous byte-lane write port and a registered read port.
// Storage is never reset; only the read-data register is.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [clog2(DEPTH_WORDS)-1:0] idx,
   input  logic                          we,
   input  logic [BYTE_LANES-1:0]         be,
   input  logic [WORD_W-1:0]             wdata,
   input  logic                          rd_en,
   input  logic                          rd_clr,
   output logic [WORD_W-1:0]             rdata
);

   logic [WORD_W-1:0] mem_r [DEPTH_WORDS];
   logic [WORD_W-1:0] rdata_r;

   // byte-lane write port
   always_ff @(posedge clk) begin
      for (int i = 0; i < BYTE_LANES; i++) begin
         if (we && be[i]) begin
            mem_r[idx][i*8 +: 8] <= wdata[i*8 +: 8];
         end
      end
   end

   // read register samples pre-write contents on the commit edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_r <= 32'h0000_0000;
      end else if (rd_clr) begin
         rdata_r <= 32'h0000_0000;
      end else if (rd_en) begin
         rdata_r <= mem_r[idx];
      end
   end

   assign rdata = rdata_r;

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: fixed wait-state latency, byte-enabled stores, one-cycle Out_Ready.
// Optional macro DMEM_ALIGN_CHECK_EN rejects misaligned accesses with Out_Err.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        In_Req,
   input  logic        In_Write,
   input  logic [31:0] In_Addr,
   input  logic [31:0] In_WData,
   input  logic [3:0]  In_ByteEn,
   output logic        Out_Ready,
   output logic [31:0] Out_RData,
   output logic        Out_Busy,
   output logic        Out_Err
);

   localparam int         AW        = clog2(DEPTH_WORDS);
   localparam logic [1:0] ST_IDLE   = 2'(IDLE);
   localparam logic [1:0] ST_WAIT   = 2'(WAIT);
   localparam logic [1:0] ST_RESP   = 2'(RESP);
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   logic [1:0]  state_r;
   logic [3:0]  count_r;
   logic        write_r;
   logic [31:0] addr_r;
   logic [31:0] wdata_r;
   logic [3:0]  byte_en_r;
   logic        ready_r;
   logic        busy_r;
   logic        err_r;

   logic        accept_s;
   logic        commit_s;
   logic        misalign_s;
   logic        c_write_s;
   logic [31:0] c_addr_s;
   logic [31:0] c_wdata_s;
   logic [3:0]  c_byte_en_s;
   logic        unused_s;

   // with zero wait states the commit happens on the accept edge, so live inputs feed the array
   always_comb begin
      accept_s    = 1'b0;
      commit_s    = 1'b0;
      c_write_s   = write_r;
      c_addr_s    = addr_r;
      c_wdata_s   = wdata_r;
      c_byte_en_s = byte_en_r;
      if (state_r == ST_IDLE) begin
         accept_s    = In_Req;
         commit_s    = In_Req && (WAIT_INIT == 4'd0);
         c_write_s   = In_Write;
         c_addr_s    = In_Addr;
         c_wdata_s   = In_WData;
         c_byte_en_s = In_ByteEn;
      end else begin
         commit_s = (state_r == ST_WAIT) && (count_r == 4'd1);
      end
   end

`ifdef DMEM_ALIGN_CHECK_EN
   assign misalign_s = (c_addr_s[1:0] != 2'b00);
`else
   assign misalign_s = 1'b0;
`endif

   assign unused_s = ^{c_addr_s[31:AW+2], c_addr_s[1:0]};

   // FSM, wait counter and request latches
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_r   <= ST_IDLE;
         count_r   <= 4'd0;
         write_r   <= 1'b0;
         addr_r    <= 32'h0000_0000;
         wdata_r   <= 32'h0000_0000;
         byte_en_r <= 4'b0000;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (In_Req) begin
                  state_r   <= (WAIT_INIT == 4'd0) ? ST_RESP : ST_WAIT;
                  count_r   <= WAIT_INIT;
                  write_r   <= In_Write;
                  addr_r    <= In_Addr;
                  wdata_r   <= In_WData;
                  byte_en_r <= In_ByteEn;
               end
            end
            ST_WAIT: begin
               count_r <= count_r - 4'd1;
               if (count_r == 4'd1) begin
                  state_r <= ST_RESP;
               end
            end
            ST_RESP: state_r <= ST_IDLE;
            default: state_r <= ST_IDLE;
         endcase
      end
   end

   // completion handshake outputs
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         ready_r <= 1'b0;
         busy_r  <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         ready_r <= commit_s;
         err_r   <= commit_s && misalign_s;
         if (accept_s) begin
            busy_r <= 1'b1;
         end else if (state_r == ST_RESP) begin
            busy_r <= 1'b0;
         end
      end
   end

   dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_array (
      .clk    (Clk),
      .rst_n  (Reset_n),
      .idx    (c_addr_s[AW+1:2]),
      .we     (commit_s && c_write_s && !misalign_s),
      .be     (c_byte_en_s),
      .wdata  (c_wdata_s),
      .rd_en  (commit_s && !c_write_s && !misalign_s),
      .rd_clr (commit_s && (c_write_s || misalign_s)),
      .rdata  (Out_RData)
   );

   assign Out_Ready = ready_r;
   assign Out_Busy  = busy_r;
   assign Out_Err   = err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: table of accesses with a response scoreboard, plus reset-abort and back-to-back sequences.
module tb_dmem_responder;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } resp_t;

`ifdef DMEM_ALIGN_CHECK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req, wr;
   logic [31:0] addr, wdata;
   logic [3:0]  be;
   logic        ready, busy, err;
   logic [31:0] rdata;

   logic        req0, wr0;
   logic [31:0] addr0, wdata0;
   logic [3:0]  be0;
   logic        ready0, busy0, err0;
   logic [31:0] rdata0;

   int          n_pass  = 0;
   int          n_total = 0;
   resp_t       sb_q[$];
   vec_t        vecs[$];

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u_dut (
      .Clk(clk), .Reset_n(rst_n), .In_Req(req), .In_Write(wr), .In_Addr(addr),
      .In_WData(wdata), .In_ByteEn(be), .Out_Ready(ready), .Out_RData(rdata),
      .Out_Busy(busy), .Out_Err(err)
   );

   dmem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) u_dut0 (
      .Clk(clk), .Reset_n(rst_n), .In_Req(req0), .In_Write(wr0), .In_Addr(addr0),
      .In_WData(wdata0), .In_ByteEn(be0), .Out_Ready(ready0), .Out_RData(rdata0),
      .Out_Busy(busy0), .Out_Err(err0)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: actual %h required %h", name, act, exp);
      end
   endtask

   task automatic access(input int idx, input vec_t v);
      resp_t exp_r;
      int    lat;
      logic  busy_ok;
      sb_q.push_back('{v.exp_rdata, v.exp_err});
      @(negedge clk);
      req = 1'b1; wr = v.wr; addr = v.addr; wdata = v.wdata; be = v.be;
      lat = 0;
      busy_ok = 1'b1;
      @(posedge clk);
      while (lat < 20) begin
         @(negedge clk);
         lat++;
         if (busy !== 1'b1) busy_ok = 1'b0;
         if (ready === 1'b1) break;
      end
      req = 1'b0;
      exp_r = sb_q.pop_front();
      check($sformatf("v%0d_latency", idx), 32'(lat), 32'd3);
      check($sformatf("v%0d_busy_held", idx), {31'd0, busy_ok}, 32'd1);
      check($sformatf("v%0d_rdata", idx), rdata, exp_r.rdata);
      check($sformatf("v%0d_err", idx), {31'd0, err}, {31'd0, exp_r.err});
      @(negedge clk);
      check($sformatf("v%0d_ready_pulse", idx), {31'd0, ready}, 32'd0);
      check($sformatf("v%0d_busy_drop", idx), {31'd0, busy}, 32'd0);
   endtask

   task automatic reset_abort();
      @(negedge clk);
      req = 1'b1; wr = 1'b1; addr = 32'h10; wdata = 32'h5555_5555; be = 4'hF;
      @(negedge clk);
      check("abort_busy_before", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort_ready", {31'd0, ready}, 32'd0);
      check("abort_rdata", rdata, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_err", {31'd0, err}, 32'd0);
      req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic b2b0(input string tag, input logic w, input logic [31:0] a [3],
                       input logic [31:0] d [3], input logic [31:0] exp_d [3]);
      int  n;
      logic exp_rdy;
      n = 0;
      @(negedge clk);
      req0 = 1'b1; wr0 = w; addr0 = a[0]; wdata0 = d[0]; be0 = 4'hF;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         exp_rdy = ((c % 2) == 0) && (c <= 4);
         check($sformatf("%s_c%0d_ready", tag, c), {31'd0, ready0}, {31'd0, exp_rdy});
         check($sformatf("%s_c%0d_busy", tag, c), {31'd0, busy0}, {31'd0, exp_rdy});
         if (exp_rdy) begin
            check($sformatf("%s_rdata%0d", tag, n), rdata0, exp_d[n]);
            n++;
            if (n < 3) begin
               addr0 = a[n]; wdata0 = d[n];
            end else begin
               req0 = 1'b0;
            end
         end
      end
   endtask

   initial begin
      logic [31:0] a3 [3];
      logic [31:0] d3 [3];
      logic [31:0] z3 [3];

      rst_n = 1'b0;
      req = 1'b0; wr = 1'b0; addr = 32'd0; wdata = 32'd0; be = 4'd0;
      req0 = 1'b0; wr0 = 1'b0; addr0 = 32'd0; wdata0 = 32'd0; be0 = 4'd0;

      vecs.push_back('{1'b1, 32'h0000_0010, 32'h1111_2222, 4'hF, 32'h0, 1'b0});
      vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'h1111_2222, 1'b0});
      vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'h1111_2222, 1'b0});
      vecs.push_back('{1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0});
      vecs.push_back('{1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0});
      vecs.push_back('{1'b1, 32'h0000_0020, 32'h0000_00AA, 4'b0001, 32'h0, 1'b0});
      vecs.push_back('{1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'hDEAD_BEAA, 1'b0});
      vecs.push_back('{1'b1, 32'h0000_0400, 32'h0000_1234, 4'hF, 32'h0, 1'b0});
      vecs.push_back('{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h0000_1234, 1'b0});
      vecs.push_back('{1'b0, 32'h1234_5410, 32'h0,         4'h0, 32'h1111_2222, 1'b0});
      vecs.push_back('{1'b1, 32'h0000_0030, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0});
      vecs.push_back('{1'b1, 32'h0000_0030, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0});
      vecs.push_back('{1'b0, 32'h0000_0030, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0});
      vecs.push_back('{1'b1, 32'h0000_0034, 32'h0000_0000, 4'hF, 32'h0, 1'b0});
      vecs.push_back('{1'b1, 32'h0000_0034, 32'h7766_5544, 4'b1010, 32'h0, 1'b0});
      vecs.push_back('{1'b0, 32'h0000_0034, 32'h0,         4'h0, 32'h7700_5500, 1'b0});
      vecs.push_back('{1'b1, 32'h0000_0022, 32'h9999_9999, 4'hF, 32'h0, ALIGN});
      vecs.push_back('{1'b0, 32'h0000_0020, 32'h0, 4'h0, ALIGN ? 32'hDEAD_BEAA : 32'h9999_9999, 1'b0});
      vecs.push_back('{1'b0, 32'h0000_0023, 32'h0, 4'h0, ALIGN ? 32'h0 : 32'h9999_9999, ALIGN});

      #1;
      check("rst_ready", {31'd0, ready}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         if (i == 2) reset_abort();
         access(i, vecs[i]);
      end

      a3 = '{32'h08, 32'h0C, 32'h10};
      d3 = '{32'hA5A5_A5A5, 32'h0F0F_0F0F, 32'h1357_9BDF};
      z3 = '{32'h0, 32'h0, 32'h0};
      b2b0("b2b_st", 1'b1, a3, d3, z3);
      b2b0("b2b_ld", 1'b0, a3, z3, d3);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
